// File: rtl/dac_jesd_tx_link.sv
// JESD204B 4-lane link-layer transmitter: CGS, LMFC-aligned 4-multiframe ILAS, then user data.
// Optional per-lane DATA scrambler (1+x^14+x^15) is built when JESD_TX_SCRAMBLE_EN is defined.
module dac_jesd_tx_link #(
  parameter int BEATS_PER_MF    = 16,
  parameter int ILAS_MF         = 4,
  parameter int LID0            = 0,
  parameter int SYNC_RESYNC_CYC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sync_n,
  input  logic         lmfc_edge,
  input  logic [111:0] ilas_cfg,
  input  logic [63:0]  tx_data,
  output logic         tx_ready,
  output logic [63:0]  tx_parallel_data,
  output logic [7:0]   tx_datak,
  output logic [1:0]   link_state,
  output logic [7:0]   sync_err_cnt
);
  localparam int NLANES    = 4;
  localparam int MF_OCTETS = 2 * BEATS_PER_MF;
  localparam int BW        = (BEATS_PER_MF > 1) ? $clog2(BEATS_PER_MF) : 1;
  localparam int MW        = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
  localparam int SW        = $clog2(SYNC_RESYNC_CYC + 1);

  typedef enum logic [1:0] {CGS = 2'd0, WAIT_LMFC = 2'd1, ILAS = 2'd2, DATA = 2'd3} state_t;

  state_t        state_reg, state_next;
  logic [BW-1:0] beat_reg, beat_next;
  logic [MW-1:0] mf_reg, mf_next;
  logic [SW-1:0] low_reg, low_next;
  logic [7:0]    err_reg, err_next;
  logic          sync_meta_reg, sync_s_reg;
  logic [63:0]   word_next, word_reg;
  logic [7:0]    k_next, k_reg;
  logic          ready_reg;

  // Returns {K, octet} for ILAS octet n of a multiframe on the given lane.
  function automatic logic [8:0] ilas_octet(input int n, input logic cfg_mf, input int lane,
                                            input logic [111:0] cfg);
    logic [7:0] c;
    c = 8'(n);
    ilas_octet = {1'b0, c};
    if (cfg_mf && n >= 2 && n <= 15) begin
      c = cfg[8*(n-2) +: 8];
      if (n == 4)  c[4:0] = 5'(LID0 + lane);
      if (n == 15) c = c + 8'(lane);
      ilas_octet = {1'b0, c};
    end
    if (cfg_mf && n == 1)      ilas_octet = {1'b1, 8'h9C};
    if (n == 0)                ilas_octet = {1'b1, 8'h1C};
    if (n == MF_OCTETS - 1)    ilas_octet = {1'b1, 8'h7C};
  endfunction

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    mf_next    = mf_reg;
    low_next   = '0;
    err_next   = err_reg;
    case (state_reg)
      CGS: if (sync_s_reg) state_next = WAIT_LMFC;
      WAIT_LMFC: begin
        if (!sync_s_reg) begin
          state_next = CGS;
        end else if (lmfc_edge) begin
          state_next = ILAS;
          beat_next  = '0;
          mf_next    = '0;
        end
      end
      ILAS: begin
        if (!sync_s_reg) begin
          state_next = CGS;
        end else if (beat_reg == BW'(BEATS_PER_MF - 1)) begin
          beat_next = '0;
          if (mf_reg == MW'(ILAS_MF - 1)) begin
            state_next = DATA;
            mf_next    = '0;
          end else begin
            mf_next = mf_reg + 1'b1;
          end
        end else begin
          beat_next = beat_reg + 1'b1;
        end
      end
      DATA: begin
        if (!sync_s_reg) begin
          if (low_reg == SW'(SYNC_RESYNC_CYC - 1)) state_next = CGS;
          else                                     low_next   = low_reg + 1'b1;
        end else if (low_reg != '0 && err_reg != 8'hFF) begin
          err_next = err_reg + 8'd1;
        end
      end
      default: state_next = CGS;
    endcase
  end

  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [17:0] ilas_pair;
    logic [15:0] lane_word, data_lane;
    logic [1:0]  lane_k;

    for (genvar gj = 0; gj < 2; gj++) begin : g_oct
      assign ilas_pair[9*gj +: 9] = ilas_octet(2 * int'(beat_reg) + gj, mf_reg == MW'(1), gi, ilas_cfg);
    end

`ifdef JESD_TX_SCRAMBLE_EN
    // scr_reg[0] holds the most recent scrambled bit; taps at delays 14 and 15.
    logic [14:0] scr_reg, scr_next;
    always_comb begin
      scr_next  = scr_reg;
      data_lane = '0;
      for (int o = 0; o < 2; o++) begin
        for (int b = 7; b >= 0; b--) begin
          data_lane[8*o+b] = tx_data[16*gi+8*o+b] ^ scr_next[13] ^ scr_next[14];
          scr_next         = {scr_next[13:0], data_lane[8*o+b]};
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst || state_reg != DATA) scr_reg <= 15'h7FFF;
      else                          scr_reg <= scr_next;
    end
`else
    assign data_lane = tx_data[16*gi +: 16];
`endif

    always_comb begin
      lane_word = 16'hBCBC;
      lane_k    = 2'b11;
      case (state_reg)
        ILAS: begin
          lane_word = {ilas_pair[16:9], ilas_pair[7:0]};
          lane_k    = {ilas_pair[17], ilas_pair[8]};
        end
        DATA: begin
          lane_word = data_lane;
          lane_k    = 2'b00;
        end
        default: ;
      endcase
    end

    assign word_next[16*gi +: 16] = lane_word;
    assign k_next[2*gi +: 2]      = lane_k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta_reg <= 1'b0;
      sync_s_reg    <= 1'b0;
      state_reg     <= CGS;
      beat_reg      <= '0;
      mf_reg        <= '0;
      low_reg       <= '0;
      err_reg       <= '0;
      word_reg      <= 64'hBCBC_BCBC_BCBC_BCBC;
      k_reg         <= 8'hFF;
      ready_reg     <= 1'b0;
    end else begin
      sync_meta_reg <= sync_n;
      sync_s_reg    <= sync_meta_reg;
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      mf_reg        <= mf_next;
      low_reg       <= low_next;
      err_reg       <= err_next;
      word_reg      <= word_next;
      k_reg         <= k_next;
      ready_reg     <= (state_next == DATA);
    end
  end

  assign tx_ready         = ready_reg;
  assign tx_parallel_data = word_reg;
  assign tx_datak         = k_reg;
  assign link_state       = state_reg;
  assign sync_err_cnt     = err_reg;
endmodule

// File: tb/tb_dac_jesd_tx_link.sv
// Bench for dac_jesd_tx_link: ILAS octet tables built from the link rules, random DATA
// traffic with short SYNC~ pulses, resync, saturation and mid-ILAS reset sequences.
module tb_dac_jesd_tx_link;
  localparam int NMF = 4;
  localparam int MFO = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         sync_n;
  logic         lmfc_edge;
  logic [111:0] ilas_cfg;
  logic [63:0]  tx_data;
  logic         tx_ready;
  logic [63:0]  tx_parallel_data;
  logic [7:0]   tx_datak;
  logic [1:0]   link_state;
  logic [7:0]   sync_err_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  cfg_oct [14];
  logic [7:0]  exp_oct [4][NMF*MFO];
  logic        exp_k   [4][NMF*MFO];
  logic [63:0] obs_w   [64];
  logic [7:0]  obs_k   [64];
  int          err_model;

  typedef struct {
    int          mf;
    int          beat;
    int          lane;
    logic [15:0] w;
    logic [1:0]  k;
  } ilas_vec_t;

  typedef struct {
    logic [63:0] din;
    logic [63:0] dout;
    logic [7:0]  k;
  } data_vec_t;

  ilas_vec_t ilas_tab [13];
  data_vec_t data_tab [4];

`ifdef JESD_TX_SCRAMBLE_EN
  bit ybits [4][64];
  int ypos;
`endif

  dac_jesd_tx_link #(
    .BEATS_PER_MF(16), .ILAS_MF(NMF), .LID0(0), .SYNC_RESYNC_CYC(4)
  ) dut (
    .clk(clk), .rst(rst), .sync_n(sync_n), .lmfc_edge(lmfc_edge), .ilas_cfg(ilas_cfg),
    .tx_data(tx_data), .tx_ready(tx_ready), .tx_parallel_data(tx_parallel_data),
    .tx_datak(tx_datak), .link_state(link_state), .sync_err_cnt(sync_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected ILAS stream: ramp everywhere, then frame markers, then the config multiframe.
  task automatic build_ilas_model();
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < NMF*MFO; i++) begin
        exp_oct[l][i] = 8'(i % MFO);
        exp_k[l][i]   = 1'b0;
      end
      for (int m = 0; m < NMF; m++) begin
        exp_oct[l][m*MFO]         = 8'h1C; exp_k[l][m*MFO]         = 1'b1;
        exp_oct[l][m*MFO+MFO-1]   = 8'h7C; exp_k[l][m*MFO+MFO-1]   = 1'b1;
      end
      exp_oct[l][MFO+1] = 8'h9C; exp_k[l][MFO+1] = 1'b1;
      for (int c = 0; c < 14; c++) exp_oct[l][MFO+2+c] = cfg_oct[c];
      exp_oct[l][MFO+4][4:0] = 5'(l);
      exp_oct[l][MFO+15]     = cfg_oct[13] + 8'(l);
    end
  endtask

  task automatic model_seed();
`ifdef JESD_TX_SCRAMBLE_EN
    for (int l = 0; l < 4; l++)
      for (int i = 0; i < 15; i++) ybits[l][i] = 1'b1;
    ypos = 15;
`endif
  endtask

  task automatic model_data(input logic [63:0] d, output logic [63:0] e);
    e = '0;
`ifdef JESD_TX_SCRAMBLE_EN
    begin
      int p;
      bit y;
      p = ypos;
      for (int l = 0; l < 4; l++) begin
        p = ypos;
        for (int o = 0; o < 2; o++)
          for (int b = 7; b >= 0; b--) begin
            y = d[16*l+8*o+b] ^ ybits[l][(p-14)%64] ^ ybits[l][(p-15)%64];
            ybits[l][p%64] = y;
            e[16*l+8*o+b]  = y;
            p++;
          end
      end
      ypos = p;
    end
`else
    e = d;
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, " word"}, tx_parallel_data, 64'hBCBC_BCBC_BCBC_BCBC);
    check({tag, " datak"}, tx_datak, 8'hFF);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget);
    int n;
    n = 0;
    while (link_state !== st && n < budget) begin
      tick();
      n++;
    end
    check("wait link_state", link_state, st);
  endtask

  task automatic run_ilas(input int nbeats, input bit record);
    logic [63:0] ew;
    logic [7:0]  ek;
    check("pre-ilas state", link_state, 2'd1);
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    check("ilas entry state", link_state, 2'd2);
    for (int k = 0; k < nbeats; k++) begin
      tx_data   = {$urandom, $urandom};
      lmfc_edge = (k % 16 == 15);
      tick();
      for (int l = 0; l < 4; l++) begin
        ew[16*l +: 16] = {exp_oct[l][2*k+1], exp_oct[l][2*k]};
        ek[2*l +: 2]   = {exp_k[l][2*k+1], exp_k[l][2*k]};
      end
      check("ilas word", tx_parallel_data, ew);
      check("ilas datak", tx_datak, ek);
      check("ilas link_state", link_state, (k == 63) ? 2'd3 : 2'd2);
      check("ilas tx_ready", tx_ready, (k == 63) ? 1'b1 : 1'b0);
      if (record) begin
        obs_w[k] = tx_parallel_data;
        obs_k[k] = tx_datak;
      end
      $display("[TB] ilas beat %0d word=%h k=%h", k, tx_parallel_data, tx_datak);
    end
    lmfc_edge = 1'b0;
  endtask

  task automatic data_cycle(input logic sync_val);
    logic [63:0] d, e;
    d = {$urandom, $urandom};
    model_data(d, e);
    tx_data = d;
    sync_n  = sync_val;
    tick();
    check("data word", tx_parallel_data, e);
    check("data datak", tx_datak, 8'h00);
    check("data tx_ready", tx_ready, 1'b1);
    check("data link_state", link_state, 2'd3);
    $display("[TB] data in=%h out=%h sync_n=%b err=%0d", d, tx_parallel_data, sync_val, sync_err_cnt);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, gap;
    logic [63:0] exp;

    for (int c = 0; c < 14; c++) cfg_oct[c] = 8'h10 + 8'(c);
    cfg_oct[2]  = 8'h00;
    cfg_oct[13] = 8'h2A;
    for (int c = 0; c < 14; c++) ilas_cfg[8*c +: 8] = cfg_oct[c];
    build_ilas_model();

    ilas_tab[0]  = '{0, 0, 0, 16'h011C, 2'b01};
    ilas_tab[1]  = '{0, 15, 0, 16'h7C1E, 2'b10};
    ilas_tab[2]  = '{1, 0, 3, 16'h9C1C, 2'b11};
    ilas_tab[3]  = '{1, 1, 3, 16'h1110, 2'b00};
    ilas_tab[4]  = '{1, 2, 3, 16'h1303, 2'b00};
    ilas_tab[5]  = '{1, 2, 0, 16'h1300, 2'b00};
    ilas_tab[6]  = '{1, 7, 3, 16'h2D1C, 2'b00};
    ilas_tab[7]  = '{1, 7, 0, 16'h2A1C, 2'b00};
    ilas_tab[8]  = '{1, 8, 2, 16'h1110, 2'b00};
    ilas_tab[9]  = '{2, 1, 0, 16'h0302, 2'b00};
    ilas_tab[10] = '{3, 15, 1, 16'h7C1E, 2'b10};
    ilas_tab[11] = '{1, 15, 2, 16'h7C1E, 2'b10};
    ilas_tab[12] = '{1, 6, 1, 16'h1B1A, 2'b00};

    data_tab[0] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'h00};
    data_tab[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00};
    data_tab[2] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 8'h00};
    data_tab[3] = '{64'hBCBC_1C7C_9CBC_BCBC, 64'hBCBC_1C7C_9CBC_BCBC, 8'h00};

    rst = 1'b1; sync_n = 1'b0; lmfc_edge = 1'b0; tx_data = '0;
    repeat (3) tick();
    check_idle("reset");
    check("reset link_state", link_state, 2'd0);
    check("reset tx_ready", tx_ready, 1'b0);
    check("reset sync_err_cnt", sync_err_cnt, 8'd0);

    rst = 1'b0;
    repeat (4) tick();
    check_idle("cgs hold");
    check("cgs hold state", link_state, 2'd0);

    // SYNC~ dropping in the same cycle as an LMFC edge keeps the link in CGS.
    sync_n = 1'b1;
    wait_state(2'd1, 10);
    sync_n = 1'b0;
    tick();
    tick();
    lmfc_edge = 1'b1;
    tick();
    lmfc_edge = 1'b0;
    check("sync vs lmfc state", link_state, 2'd0);
    $display("[TB] wait_lmfc sync drop with lmfc -> state %0d", link_state);

    sync_n = 1'b1;
    wait_state(2'd1, 10);
    repeat (5) tick();
    check_idle("wait_lmfc");
    run_ilas(64, 1'b1);

    foreach (ilas_tab[i]) begin
      int k;
      k = ilas_tab[i].mf * 16 + ilas_tab[i].beat;
      check("ilas table word", obs_w[k][16*ilas_tab[i].lane +: 16], ilas_tab[i].w);
      check("ilas table k", obs_k[k][2*ilas_tab[i].lane +: 2], ilas_tab[i].k);
      $display("[TB] ilas vec mf=%0d beat=%0d lane=%0d word=%h", ilas_tab[i].mf, ilas_tab[i].beat,
               ilas_tab[i].lane, obs_w[k][16*ilas_tab[i].lane +: 16]);
    end

    model_seed();
    err_model = 0;
    repeat (5) data_cycle(1'b1);
    for (int p = 0; p < 12; p++) begin
      len = (p == 0) ? 2 : (p == 1) ? 3 : int'($urandom_range(1, 3));
      gap = int'($urandom_range(4, 8));
      repeat (len) data_cycle(1'b0);
      repeat (gap) data_cycle(1'b1);
      err_model = (err_model < 255) ? err_model + 1 : 255;
      check("sync_err_cnt", sync_err_cnt, 8'(err_model));
    end

    for (int i = 0; i < 256; i++) begin
      data_cycle(1'b0);
      data_cycle(1'b1);
    end
    repeat (4) data_cycle(1'b1);
    check("sync_err_cnt saturate", sync_err_cnt, 8'd255);

    sync_n = 1'b0;
    wait_state(2'd0, 12);
    check("resync tx_ready", tx_ready, 1'b0);
    check("resync err unchanged", sync_err_cnt, 8'd255);
    tick();
    check_idle("resync");
    $display("[TB] resync -> state %0d word=%h", link_state, tx_parallel_data);

    sync_n = 1'b1;
    wait_state(2'd1, 12);
    run_ilas(39, 1'b0);
    rst = 1'b1;
    tick();
    check_idle("mid-ilas reset");
    check("mid-ilas reset state", link_state, 2'd0);
    check("mid-ilas reset tx_ready", tx_ready, 1'b0);
    check("mid-ilas reset err", sync_err_cnt, 8'd0);
    $display("[TB] reset at mf2 beat7 -> word=%h", tx_parallel_data);
    rst = 1'b0;
    wait_state(2'd1, 12);
    run_ilas(64, 1'b0);

    model_seed();
    foreach (data_tab[i]) begin
      exp = data_tab[i].dout;
`ifdef JESD_TX_SCRAMBLE_EN
      model_data(data_tab[i].din, exp);
`endif
      tx_data = data_tab[i].din;
      tick();
      check("data table word", tx_parallel_data, exp);
      check("data table k", tx_datak, data_tab[i].k);
      $display("[TB] data vec in=%h out=%h", data_tab[i].din, tx_parallel_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
